// File: rtl/ecc_opnd_buf_pkg.sv
// Shared definitions for the ECC operand buffer: receive FSM state encoding
// and a constant-evaluable ceil(log2) helper used to size counters.
package ecc_opnd_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RCV  = 2'd1,
    ST_ERR  = 2'd2
  } rcv_state_e;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/ecc_opnd_zchk.sv
// Registered zero detect for one operand.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (flag forced to 1, matching a cleared operand)
//   op         : operand to test
//   zero       : 1 when op was all-zero at the previous clock edge
module ecc_opnd_zchk #(
  parameter int OPW = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic [OPW-1:0] op,
  output logic           zero
);

  logic zero_q;
  logic zero_d;

  always_comb begin
    zero_d = (op == '0);
    if (clr) zero_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zero_q <= 1'b1;
    else        zero_q <= zero_d;
  end

  assign zero = zero_q;

endmodule

// File: rtl/ecc_opnd_buf.sv
// Operand/result buffer for ECC-class cores.
// Assembles DW-bit write words into NOPND operands of OPW bits, checks the
// received length against the armed transfer size, flags all-zero operands,
// and offers registered word read-back of NRES captured engine results.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   clr                 : synchronous clear of all state
//   load_rcv, wr_size   : arm a receive of wr_size bytes
//   wr_en/wr_addr/wr_d  : word write strobe, word address, data
//   rcv_done            : one-cycle pulse after the last expected word
//   rcv_err             : sticky size/address error
//   opnd                : operand i at [i*OPW +: OPW]
//   flg_zero            : bit i set when operand i is zero
//   res_ld, res_d       : capture engine results
//   rd_addr, rd_d       : result word address, registered read data
// Word a maps to operand a/WPO, slice a%WPO; slice 0 is the MS word.
module ecc_opnd_buf
  import ecc_opnd_buf_pkg::*;
#(
  parameter int DW    = 32,
  parameter int OPW   = 256,
  parameter int NOPND = 4,
  parameter int NRES  = 2,
  parameter int AW    = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 load_rcv,
  input  logic [15:0]          wr_size,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_d,
  output logic                 rcv_done,
  output logic                 rcv_err,
  output logic [NOPND*OPW-1:0] opnd,
  output logic [NOPND-1:0]     flg_zero,
  input  logic                 res_ld,
  input  logic [NRES*OPW-1:0]  res_d,
  input  logic [AW-1:0]        rd_addr,
  output logic [DW-1:0]        rd_d
);

  localparam int WPO = OPW / DW;
  localparam int NW  = NOPND * WPO;
  localparam int NRW = NRES * WPO;
  localparam int CW  = clog2(NW + 1);

  rcv_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] exp_q, exp_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic [15:0]   size_words;
  logic          size_bad;
  logic          wr_in_range;
  logic          wr_fire;
  logic [CW-1:0] cnt_inc;
  logic [DW-1:0] res_word [NRW];

  // Size is checked at full width before being narrowed to the counter width,
  // so an oversize request can never alias onto a small valid count.
  assign size_words  = {2'b00, wr_size[15:2]};
  assign size_bad    = (wr_size == 16'd0) || (wr_size[1:0] != 2'b00) ||
                       (32'(size_words) > NW);
  assign wr_in_range = (32'(wr_addr) < NW);
  assign cnt_inc     = cnt_q + 1'b1;

  // A write lands only while receiving and not displaced by clr or a re-arm.
  assign wr_fire = (state_q == ST_RCV) && !clr && !load_rcv && wr_en && wr_in_range;

  //--------------------------------------------------------------------------
  // Receive FSM
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      exp_d   = '0;
      err_d   = 1'b0;
    end else if (load_rcv) begin
      // Same evaluation from every state; a load in RCV restarts the count.
      if (size_bad) begin
        state_d = ST_ERR;
        err_d   = 1'b1;
      end else begin
        state_d = ST_RCV;
        cnt_d   = '0;
        exp_d   = CW'(size_words);
        err_d   = 1'b0;
      end
    end else begin
      case (state_q)
        ST_RCV: begin
          if (wr_en) begin
            if (wr_in_range) begin
              cnt_d = cnt_inc;
              if (cnt_inc == exp_q) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end else begin
              state_d = ST_ERR;
              err_d   = 1'b1;
            end
          end
        end
        default: ;  // IDLE and ERR wait for clr or load_rcv
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      exp_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign rcv_done = done_q;
  assign rcv_err  = err_q;

  //--------------------------------------------------------------------------
  // Operand registers, word write decode and zero flags
  //--------------------------------------------------------------------------
  for (genvar gi = 0; gi < NOPND; gi++) begin : g_opnd
    logic [OPW-1:0] op_q, op_d;

    always_comb begin
      op_d = op_q;
      if (clr) begin
        op_d = '0;
      end else if (wr_fire) begin
        for (int s = 0; s < WPO; s++) begin
          if (32'(wr_addr) == gi * WPO + s) op_d[OPW-1-s*DW -: DW] = wr_d;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) op_q <= '0;
      else        op_q <= op_d;
    end

    assign opnd[gi*OPW +: OPW] = op_q;

    ecc_opnd_zchk #(.OPW(OPW)) u_zchk (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .op    (op_q),
      .zero  (flg_zero[gi])
    );
  end

  //--------------------------------------------------------------------------
  // Result registers and word view for read-back
  //--------------------------------------------------------------------------
  for (genvar gi = 0; gi < NRES; gi++) begin : g_res
    logic [OPW-1:0] rslt_q, rslt_d;

    always_comb begin
      rslt_d = rslt_q;
      if (clr)         rslt_d = '0;
      else if (res_ld) rslt_d = res_d[gi*OPW +: OPW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rslt_q <= '0;
      else        rslt_q <= rslt_d;
    end

    for (genvar si = 0; si < WPO; si++) begin : g_word
      assign res_word[gi*WPO + si] = rslt_q[OPW-1-si*DW -: DW];
    end
  end

  // Reads see the registered results, so a same-cycle res_ld returns the
  // pre-load word. Out-of-range addresses match no entry and read as 0.
  always_comb begin
    rdata_d = '0;
    if (!clr) begin
      for (int i = 0; i < NRW; i++) begin
        if (32'(rd_addr) == i) rdata_d = res_word[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rd_d = rdata_q;

endmodule

// File: tb/tb_ecc_opnd_buf.sv
module tb_ecc_opnd_buf;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          load_rcv;
  logic [15:0]   wr_size;
  logic          wr_en;
  logic [13:0]   wr_addr;
  logic [31:0]   wr_d;
  logic          rcv_done;
  logic          rcv_err;
  logic [1023:0] opnd;
  logic [3:0]    flg_zero;
  logic          res_ld;
  logic [511:0]  res_d;
  logic [13:0]   rd_addr;
  logic [31:0]   rd_d;

  int n_checks;
  int n_errors;

  logic [255:0] exp_op [4];

  ecc_opnd_buf dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load_rcv (load_rcv),
    .wr_size  (wr_size),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_d     (wr_d),
    .rcv_done (rcv_done),
    .rcv_err  (rcv_err),
    .opnd     (opnd),
    .flg_zero (flg_zero),
    .res_ld   (res_ld),
    .res_d    (res_d),
    .rd_addr  (rd_addr),
    .rd_d     (rd_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] req);
    n_checks++;
    if (obs !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, req);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] size);
    $display("load_rcv wr_size=%0d", size);
    load_rcv = 1'b1;
    wr_size  = size;
    tick();
    load_rcv = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    $display("write addr=%0d data=%h", a, d);
    wr_en   = 1'b1;
    wr_addr = 14'(a);
    wr_d    = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic chk_opnds(input string tag);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_op%0d", tag, i), opnd[i*256 +: 256], exp_op[i]);
  endtask

  task automatic chk_reset_state(input string tag);
    for (int i = 0; i < 4; i++) exp_op[i] = '0;
    chk_opnds(tag);
    chk({tag, "_zero"}, 256'(flg_zero), 256'(4'hF));
    chk({tag, "_done"}, 256'(rcv_done), 256'(1'b0));
    chk({tag, "_err"},  256'(rcv_err),  256'(1'b0));
    chk({tag, "_rd"},   256'(rd_d),     256'(32'h0));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; clr = 1'b0; load_rcv = 1'b0; wr_size = '0;
    wr_en = 1'b0; wr_addr = '0; wr_d = '0;
    res_ld = 1'b0; res_d = '0; rd_addr = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    $display("reset released");
    chk_reset_state("rst_init");

    // Reset asserted in the middle of a receive
    load(16'd128);
    wr(0, 32'hCAFE0001);
    wr(1, 32'hCAFE0002);
    tick();
    #2 rst_n = 1'b0;
    #1 $display("async reset mid-RCV");
    chk_reset_state("rst_mid");
    tick();
    rst_n = 1'b1;
    tick();

    // Full 128-byte receive, data = addr+1
    load(16'd128);
    for (int a = 0; a < 32; a++) begin
      wr(a, 32'(a + 1));
      if (a == 30) chk("full_done_early", 256'(rcv_done), 256'(1'b0));
      if (a == 31) chk("full_done", 256'(rcv_done), 256'(1'b1));
    end
    tick();
    $display("full receive settled");
    chk("full_done_pulse", 256'(rcv_done), 256'(1'b0));
    chk("full_zero", 256'(flg_zero), 256'(4'h0));
    chk("full_op0_ms", 256'(opnd[255:224]), 256'(32'd1));
    for (int i = 0; i < 4; i++)
      for (int s = 0; s < 8; s++) exp_op[i][255 - 32*s -: 32] = 32'(i*8 + s + 1);
    chk_opnds("full");

    // Partial 64-byte receive after clr
    clr = 1'b1;
    tick();
    clr = 1'b0;
    $display("clr");
    chk("clr_zero", 256'(flg_zero), 256'(4'hF));
    load(16'd64);
    for (int a = 0; a < 16; a++) begin
      wr(a, 32'hA000 + 32'(a));
      if (a == 14) chk("half_done_early", 256'(rcv_done), 256'(1'b0));
      if (a == 15) chk("half_done", 256'(rcv_done), 256'(1'b1));
    end
    tick();
    chk("half_zero", 256'(flg_zero), 256'(4'b1100));
    for (int i = 0; i < 4; i++) exp_op[i] = '0;
    for (int i = 0; i < 2; i++)
      for (int s = 0; s < 8; s++) exp_op[i][255 - 32*s -: 32] = 32'hA000 + 32'(i*8 + s);
    chk_opnds("half");

    // Size errors
    load(16'd130);
    chk("sz130_err", 256'(rcv_err), 256'(1'b1));
    chk("sz130_done", 256'(rcv_done), 256'(1'b0));
    tick();
    chk("sz130_done2", 256'(rcv_done), 256'(1'b0));
    load(16'd4);
    chk("sz4_err_clr", 256'(rcv_err), 256'(1'b0));
    load(16'd132);
    chk("sz132_err", 256'(rcv_err), 256'(1'b1));
    load(16'd0);
    chk("sz0_err", 256'(rcv_err), 256'(1'b1));
    load(16'd4);
    chk("sz4_err_clr2", 256'(rcv_err), 256'(1'b0));

    // Address out of range while receiving
    wr(32, 32'hFFFFFFFF);
    chk("addr32_err", 256'(rcv_err), 256'(1'b1));
    chk_opnds("addr32");
    wr(0, 32'h00000005);  // ignored in ERR
    tick();
    chk("err_done", 256'(rcv_done), 256'(1'b0));
    chk_opnds("err_wr");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    $display("clr");
    chk("clr_err", 256'(rcv_err), 256'(1'b0));
    chk_reset_state("clr_all");

    // Re-arm in RCV drops the same-cycle write and restarts the count
    load(16'd8);
    wr(0, 32'h11);
    $display("load_rcv wr_size=8 with write addr=1 data=00000022");
    load_rcv = 1'b1; wr_size = 16'd8;
    wr_en = 1'b1; wr_addr = 14'd1; wr_d = 32'h22;
    tick();
    load_rcv = 1'b0; wr_en = 1'b0;
    chk("rearm_done0", 256'(rcv_done), 256'(1'b0));
    wr(2, 32'h33);
    chk("rearm_done1", 256'(rcv_done), 256'(1'b0));
    wr(3, 32'h44);
    chk("rearm_done2", 256'(rcv_done), 256'(1'b1));
    tick();
    chk("rearm_op0", opnd[255:0], {32'h11, 32'h0, 32'h33, 32'h44, 128'h0});

    // Result capture and read-back
    res_d = '0;
    res_d[255:224] = 32'hDEADBEEF;
    res_d[287:256] = 32'h12345678;
    $display("res_ld with rd_addr=0");
    res_ld = 1'b1; rd_addr = 14'd0;
    tick();
    res_ld = 1'b0;
    chk("rd_preload", 256'(rd_d), 256'(32'h0));
    tick();
    $display("read addr=0");
    chk("rd_w0", 256'(rd_d), 256'(32'hDEADBEEF));
    rd_addr = 14'd15;
    tick();
    $display("read addr=15");
    chk("rd_w15", 256'(rd_d), 256'(32'h12345678));
    rd_addr = 14'd16;
    tick();
    $display("read addr=16");
    chk("rd_oor", 256'(rd_d), 256'(32'h0));
    rd_addr = 14'd0;
    clr = 1'b1; res_ld = 1'b1;
    tick();
    clr = 1'b0; res_ld = 1'b0;
    $display("clr with res_ld");
    chk("rd_clr", 256'(rd_d), 256'(32'h0));
    tick();
    $display("read addr=0 after clr");
    chk("rd_after_clr", 256'(rd_d), 256'(32'h0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
